// File: rtl/chain_decoder.sv
// chain_decoder
// Freeman chain-code decoder. Starting from a latched start point, it follows
// a stream of 3-bit direction codes, emits one pixel write per contour point,
// counts the accepted codes (Perimiter) and rebuilds the enclosed polygon area
// from a shoelace accumulator.
//
// Ports:
//   Clk         rising-edge clock
//   reset       asynchronous active-low reset
//   start       begin a decode (honoured only in IDLE or DONE)
//   start_x/y   start point, latched on start
//   code_valid  a direction code is offered
//   code        Freeman direction (0=E, 1=NE, 2=N ... 7=SE, y grows downward)
//   code_last   offered code is the last one of the contour
//   code_ready  decoder takes a code this cycle (STEP state)
//   pix_we      registered pixel write strobe
//   pix_x/y     registered pixel coordinates
//   Perimiter   number of accepted codes
//   Area        |shoelace sum| / 2, valid once Done is high
//   Done        decode finished (level)
//   Error       decode failed: out of bounds, counter overflow or open contour
//   busy        decoder is in LOAD, STEP or FINISH

module chain_decoder #(
   parameter int W       = 6,
   parameter int PERIM_W = 8,
   parameter int AREA_W  = 12
) (
   input  logic               Clk,
   input  logic               reset,
   input  logic               start,
   input  logic [W-1:0]       start_x,
   input  logic [W-1:0]       start_y,
   input  logic               code_valid,
   input  logic [2:0]         code,
   input  logic               code_last,
   output logic               code_ready,
   output logic               pix_we,
   output logic [W-1:0]       pix_x,
   output logic [W-1:0]       pix_y,
   output logic [PERIM_W-1:0] Perimiter,
   output logic [AREA_W-1:0]  Area,
   output logic               Done,
   output logic               Error,
   output logic               busy
);

   localparam int SW = 2*W + 2;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STEP,
      FINISH,
      DONE
   } state_t;

   state_t                r_state;
   logic [W-1:0]          r_startX;
   logic [W-1:0]          r_startY;
   logic [W-1:0]          r_curX;
   logic [W-1:0]          r_curY;
   logic                  r_pixWe;
   logic [W-1:0]          r_pixX;
   logic [W-1:0]          r_pixY;
   logic [PERIM_W-1:0]    r_perim;
   logic [AREA_W-1:0]     r_area;
   logic                  r_done;
   logic                  r_error;
   logic signed [SW-1:0]  r_accum;

   logic                  w_dxPos;
   logic                  w_dxNeg;
   logic                  w_dyPos;
   logic                  w_dyNeg;
   logic [W:0]            w_stepX;
   logic [W:0]            w_stepY;
   logic [W:0]            w_nextX;
   logic [W:0]            w_nextY;
   logic                  w_outOfBounds;
   logic                  w_accept;
   logic                  w_perimFull;
   logic                  w_closed;
   logic signed [SW-1:0]  w_xExt;
   logic signed [SW-1:0]  w_yExt;
   logic signed [SW-1:0]  w_accNext;
   logic signed [SW-1:0]  w_absAccum;
   logic [SW-1:0]         w_halfAccum;

   // Direction decode into unit steps on each axis.
   always_comb begin
      w_dxPos = 1'b0;
      w_dxNeg = 1'b0;
      w_dyPos = 1'b0;
      w_dyNeg = 1'b0;
      case (code)
         3'd0: begin w_dxPos = 1'b1;                   end
         3'd1: begin w_dxPos = 1'b1; w_dyNeg = 1'b1;   end
         3'd2: begin                 w_dyNeg = 1'b1;   end
         3'd3: begin w_dxNeg = 1'b1; w_dyNeg = 1'b1;   end
         3'd4: begin w_dxNeg = 1'b1;                   end
         3'd5: begin w_dxNeg = 1'b1; w_dyPos = 1'b1;   end
         3'd6: begin                 w_dyPos = 1'b1;   end
         default: begin w_dxPos = 1'b1; w_dyPos = 1'b1; end
      endcase
   end

   // The next point is formed one bit wider than the image so that stepping
   // off either edge (63+1 or 0-1) shows up as the extra top bit being set.
   always_comb begin
      w_stepX       = w_dxPos ? (W+1)'(1) : (w_dxNeg ? '1 : '0);
      w_stepY       = w_dyPos ? (W+1)'(1) : (w_dyNeg ? '1 : '0);
      w_nextX       = {1'b0, r_curX} + w_stepX;
      w_nextY       = {1'b0, r_curY} + w_stepY;
      w_outOfBounds = w_nextX[W] | w_nextY[W];
      w_closed      = (w_nextX[W-1:0] == r_startX) && (w_nextY[W-1:0] == r_startY);
   end

   // Shoelace term cur_x*dy - cur_y*dx: with unit steps it reduces to adding
   // or subtracting the current coordinates, so no multiplier is needed.
   always_comb begin
      w_xExt    = SW'(r_curX);
      w_yExt    = SW'(r_curY);
      w_accNext = r_accum;
      if (w_dyPos) begin
         w_accNext = w_accNext + w_xExt;
      end else if (w_dyNeg) begin
         w_accNext = w_accNext - w_xExt;
      end
      if (w_dxPos) begin
         w_accNext = w_accNext - w_yExt;
      end else if (w_dxNeg) begin
         w_accNext = w_accNext + w_yExt;
      end
      w_absAccum  = r_accum[SW-1] ? -r_accum : r_accum;
      w_halfAccum = w_absAccum >>> 1;
   end

   assign w_accept    = (r_state == STEP) && code_valid;
   assign w_perimFull = &r_perim;

   // Main controller. The strobe pix_we is a one-cycle pulse: it defaults low
   // and is raised only for the start point (entering LOAD) and for each
   // accepted in-bounds step, so gaps in code_valid never produce writes.
   // An out-of-bounds or overflowing accept ends the decode with Error set and
   // leaves the current point untouched.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_startX <= '0;
         r_startY <= '0;
         r_curX   <= '0;
         r_curY   <= '0;
         r_pixWe  <= 1'b0;
         r_pixX   <= '0;
         r_pixY   <= '0;
         r_perim  <= '0;
         r_area   <= '0;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
         r_accum  <= '0;
      end else begin
         r_pixWe <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_startX <= start_x;
                  r_startY <= start_y;
                  r_curX   <= start_x;
                  r_curY   <= start_y;
                  r_pixWe  <= 1'b1;
                  r_pixX   <= start_x;
                  r_pixY   <= start_y;
                  r_perim  <= '0;
                  r_accum  <= '0;
                  r_done   <= 1'b0;
                  r_error  <= 1'b0;
                  r_state  <= LOAD;
               end
            end
            LOAD: begin
               r_state <= STEP;
            end
            STEP: begin
               if (w_accept) begin
                  if (w_perimFull) begin
                     r_error <= 1'b1;
                     r_state <= FINISH;
                  end else begin
                     r_perim <= r_perim + 1'b1;
                     if (w_outOfBounds) begin
                        r_error <= 1'b1;
                        r_state <= FINISH;
                     end else begin
                        r_curX  <= w_nextX[W-1:0];
                        r_curY  <= w_nextY[W-1:0];
                        r_pixWe <= 1'b1;
                        r_pixX  <= w_nextX[W-1:0];
                        r_pixY  <= w_nextY[W-1:0];
                        r_accum <= w_accNext;
                        if (code_last) begin
                           r_state <= FINISH;
                           if (!w_closed) begin
                              r_error <= 1'b1;
                           end
                        end
                     end
                  end
               end
            end
            FINISH: begin
               r_area  <= AREA_W'(w_halfAccum);
               r_done  <= 1'b1;
               r_state <= DONE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign code_ready = (r_state == STEP);
   assign busy       = (r_state == LOAD) || (r_state == STEP) || (r_state == FINISH);
   assign pix_we     = r_pixWe;
   assign pix_x      = r_pixX;
   assign pix_y      = r_pixY;
   assign Perimiter  = r_perim;
   assign Area       = r_area;
   assign Done       = r_done;
   assign Error      = r_error;

endmodule

// File: tb/tb_chain_decoder.sv
// tb_chain_decoder
// Directed bench for chain_decoder: square, triangle, open contour, bounds,
// gapped code stream with a start poke while busy, and reset mid-decode.

module tb_chain_decoder;

   localparam int W       = 6;
   localparam int PERIM_W = 8;
   localparam int AREA_W  = 12;

   logic               clock;
   logic               rstN;
   logic               start;
   logic [W-1:0]       startX;
   logic [W-1:0]       startY;
   logic               codeValid;
   logic [2:0]         code;
   logic               codeLast;
   logic               codeReady;
   logic               pixWe;
   logic [W-1:0]       pixX;
   logic [W-1:0]       pixY;
   logic [PERIM_W-1:0] perim;
   logic [AREA_W-1:0]  area;
   logic               done;
   logic               error;
   logic               busy;

   int cmpCount;
   int failCount;

   int          resWrites;
   int          resGapWrites;
   logic [W-1:0] resLastX;
   logic [W-1:0] resLastY;
   bit          resTimeout;
   logic        resBusyAtPoke;

   chain_decoder #(
      .W(W),
      .PERIM_W(PERIM_W),
      .AREA_W(AREA_W)
   ) dut (
      .Clk(clock),
      .reset(rstN),
      .start(start),
      .start_x(startX),
      .start_y(startY),
      .code_valid(codeValid),
      .code(code),
      .code_last(codeLast),
      .code_ready(codeReady),
      .pix_we(pixWe),
      .pix_x(pixX),
      .pix_y(pixY),
      .Perimiter(perim),
      .Area(area),
      .Done(done),
      .Error(error),
      .busy(busy)
   );

   // Free-running clock, 10 time units per period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one cycle; everything is driven and observed 1 unit after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Run one contour: pulse start, feed the codes (digits of a string), and
   // wait for Done. gapMask bit (cycle % 32) withholds code_valid for that
   // cycle; pokeStart raises start with a different point while busy.
   task automatic runContour(input logic [W-1:0] sx, input logic [W-1:0] sy,
                             input string codes, input logic [31:0] gapMask,
                             input bit pokeStart);
      int   idx;
      int   cyc;
      int   n;
      byte  b;
      logic acc;
      n             = codes.len();
      resWrites     = 0;
      resGapWrites  = 0;
      resTimeout    = 1'b0;
      resBusyAtPoke = 1'b0;
      resLastX      = '0;
      resLastY      = '0;
      start  = 1'b1;
      startX = sx;
      startY = sy;
      tick();
      start = 1'b0;
      if (pixWe) begin
         resWrites++;
         resLastX = pixX;
         resLastY = pixY;
      end
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 200) begin
         if (gapMask[cyc % 32]) begin
            codeValid = 1'b0;
            codeLast  = 1'b0;
         end else begin
            codeValid = 1'b1;
            b         = codes[idx];
            code      = b[2:0];
            codeLast  = (idx == n - 1);
         end
         if (pokeStart && cyc == 3) begin
            start         = 1'b1;
            startX        = 6'd40;
            startY        = 6'd40;
            resBusyAtPoke = busy;
         end
         acc = codeValid && codeReady;
         tick();
         start = 1'b0;
         if (acc) idx++;
         if (pixWe) begin
            resWrites++;
            resLastX = pixX;
            resLastY = pixY;
            if (!acc) resGapWrites++;
         end
         cyc++;
         if (acc && error) break;
      end
      codeValid = 1'b0;
      codeLast  = 1'b0;
      if (idx < n && !error) resTimeout = 1'b1;
      cyc = 0;
      while (!done && cyc < 10) begin
         tick();
         if (pixWe) begin
            resWrites++;
            resGapWrites++;
         end
         cyc++;
      end
      if (!done) resTimeout = 1'b1;
   endtask

   task automatic test_reset();
      cmpCount++;
      if ({codeReady, pixWe, busy, done, error} !== 5'b0) begin
         $display("[TB] FAIL reset_flags: got %b expected 00000", {codeReady, pixWe, busy, done, error});
         failCount++;
      end
      cmpCount++;
      if ({pixX, pixY} !== '0) begin
         $display("[TB] FAIL reset_pix: got (%0d,%0d) expected (0,0)", pixX, pixY);
         failCount++;
      end
      cmpCount++;
      if (perim !== 8'd0) begin
         $display("[TB] FAIL reset_perim: got %0d expected 0", perim);
         failCount++;
      end
      cmpCount++;
      if (area !== 12'd0) begin
         $display("[TB] FAIL reset_area: got %0d expected 0", area);
         failCount++;
      end
   endtask

   task automatic test_square();
      runContour(6'd10, 6'd10, "00664422", 32'h0, 1'b0);
      cmpCount++;
      if (resTimeout) begin
         $display("[TB] FAIL square_timeout: got timeout expected Done");
         failCount++;
      end
      cmpCount++;
      if (resWrites != 9) begin
         $display("[TB] FAIL square_writes: got %0d expected 9", resWrites);
         failCount++;
      end
      cmpCount++;
      if (resLastX !== 6'd10 || resLastY !== 6'd10) begin
         $display("[TB] FAIL square_last_pix: got (%0d,%0d) expected (10,10)", resLastX, resLastY);
         failCount++;
      end
      cmpCount++;
      if (perim !== 8'd8) begin
         $display("[TB] FAIL square_perim: got %0d expected 8", perim);
         failCount++;
      end
      cmpCount++;
      if (area !== 12'd4) begin
         $display("[TB] FAIL square_area: got %0d expected 4", area);
         failCount++;
      end
      cmpCount++;
      if ({done, error, busy} !== 3'b100) begin
         $display("[TB] FAIL square_status: got done/err/busy=%b expected 100", {done, error, busy});
         failCount++;
      end
   endtask

   task automatic test_triangle();
      runContour(6'd0, 6'd0, "005522", 32'h0, 1'b0);
      cmpCount++;
      if (resTimeout) begin
         $display("[TB] FAIL tri_timeout: got timeout expected Done");
         failCount++;
      end
      cmpCount++;
      if (perim !== 8'd6) begin
         $display("[TB] FAIL tri_perim: got %0d expected 6", perim);
         failCount++;
      end
      cmpCount++;
      if (area !== 12'd2) begin
         $display("[TB] FAIL tri_area: got %0d expected 2", area);
         failCount++;
      end
      cmpCount++;
      if (error !== 1'b0) begin
         $display("[TB] FAIL tri_error: got %b expected 0", error);
         failCount++;
      end
   endtask

   task automatic test_open();
      runContour(6'd5, 6'd5, "00", 32'h0, 1'b0);
      cmpCount++;
      if ({done, error} !== 2'b11) begin
         $display("[TB] FAIL open_status: got done/err=%b expected 11", {done, error});
         failCount++;
      end
      cmpCount++;
      if (perim !== 8'd2) begin
         $display("[TB] FAIL open_perim: got %0d expected 2", perim);
         failCount++;
      end
      cmpCount++;
      if (resWrites != 3 || resLastX !== 6'd7 || resLastY !== 6'd5) begin
         $display("[TB] FAIL open_writes: got %0d last (%0d,%0d) expected 3 last (7,5)", resWrites, resLastX, resLastY);
         failCount++;
      end
   endtask

   task automatic test_bounds();
      runContour(6'd63, 6'd5, "0", 32'h0, 1'b0);
      cmpCount++;
      if (resWrites != 1) begin
         $display("[TB] FAIL bounds_east_writes: got %0d expected 1", resWrites);
         failCount++;
      end
      cmpCount++;
      if ({done, error} !== 2'b11 || perim !== 8'd1) begin
         $display("[TB] FAIL bounds_east_status: got done/err=%b perim=%0d expected 11 perim=1", {done, error}, perim);
         failCount++;
      end
      runContour(6'd0, 6'd0, "2", 32'h0, 1'b0);
      cmpCount++;
      if (resWrites != 1) begin
         $display("[TB] FAIL bounds_north_writes: got %0d expected 1", resWrites);
         failCount++;
      end
      cmpCount++;
      if ({done, error} !== 2'b11 || perim !== 8'd1) begin
         $display("[TB] FAIL bounds_north_status: got done/err=%b perim=%0d expected 11 perim=1", {done, error}, perim);
         failCount++;
      end
   endtask

   task automatic test_back_to_back();
      runContour(6'd10, 6'd10, "00664422", 32'h4B29_6D92, 1'b1);
      cmpCount++;
      if (resTimeout) begin
         $display("[TB] FAIL gap_timeout: got timeout expected Done");
         failCount++;
      end
      cmpCount++;
      if (resBusyAtPoke !== 1'b1) begin
         $display("[TB] FAIL gap_busy: got %b expected 1", resBusyAtPoke);
         failCount++;
      end
      cmpCount++;
      if (resWrites != 9 || resGapWrites != 0) begin
         $display("[TB] FAIL gap_writes: got %0d writes %0d stray expected 9 writes 0 stray", resWrites, resGapWrites);
         failCount++;
      end
      cmpCount++;
      if (resLastX !== 6'd10 || resLastY !== 6'd10) begin
         $display("[TB] FAIL gap_last_pix: got (%0d,%0d) expected (10,10)", resLastX, resLastY);
         failCount++;
      end
      cmpCount++;
      if (perim !== 8'd8 || area !== 12'd4 || error !== 1'b0 || done !== 1'b1) begin
         $display("[TB] FAIL gap_result: got perim=%0d area=%0d err=%b done=%b expected 8 4 0 1", perim, area, error, done);
         failCount++;
      end
   endtask

   task automatic test_reset_mid();
      int  cyc;
      int  accepted;
      byte b;
      string codes;
      codes  = "00664422";
      start  = 1'b1;
      startX = 6'd20;
      startY = 6'd20;
      tick();
      start    = 1'b0;
      accepted = 0;
      cyc      = 0;
      while (accepted < 3 && cyc < 20) begin
         codeValid = 1'b1;
         b         = codes[accepted];
         code      = b[2:0];
         codeLast  = 1'b0;
         if (codeReady) accepted++;
         tick();
         cyc++;
      end
      codeValid = 1'b0;
      cmpCount++;
      if (accepted != 3 || perim !== 8'd3 || busy !== 1'b1) begin
         $display("[TB] FAIL midreset_pre: got accepted=%0d perim=%0d busy=%b expected 3 3 1", accepted, perim, busy);
         failCount++;
      end
      #2;
      rstN = 1'b0;
      #1;
      cmpCount++;
      if ({codeReady, pixWe, busy, done, error} !== 5'b0 || {pixX, pixY} !== '0 ||
          perim !== 8'd0 || area !== 12'd0) begin
         $display("[TB] FAIL midreset_outputs: got rdy/we/busy/done/err=%b pix=(%0d,%0d) perim=%0d area=%0d expected all 0",
                  {codeReady, pixWe, busy, done, error}, pixX, pixY, perim, area);
         failCount++;
      end
      tick();
      rstN = 1'b1;
      tick();
      runContour(6'd10, 6'd10, "00664422", 32'h0, 1'b0);
      cmpCount++;
      if (resTimeout || perim !== 8'd8 || area !== 12'd4 || error !== 1'b0) begin
         $display("[TB] FAIL midreset_square: got perim=%0d area=%0d err=%b timeout=%b expected 8 4 0 0",
                  perim, area, error, resTimeout);
         failCount++;
      end
   endtask

   // Test sequence: reset, then each scenario back to back (restarting from DONE).
   initial begin
      cmpCount  = 0;
      failCount = 0;
      rstN      = 1'b0;
      start     = 1'b0;
      startX    = '0;
      startY    = '0;
      codeValid = 1'b0;
      code      = '0;
      codeLast  = 1'b0;
      tick();
      tick();
      rstN = 1'b1;
      tick();
      test_reset();
      test_square();
      test_triangle();
      test_open();
      test_bounds();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
      $finish;
   end

endmodule
